// File: rtl/msrv32_pkg.sv
// Shared msrv32 core constants: register width, register addressing and the x0 address.
// Imported by the register file, the write-enable generator and the decoder.
package msrv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int X0_ADDR    = 0;

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One register-file read port: reset/x0/bypass/array select, fully combinational (0 cycles).
// No flow control; the write-back bypass puts wr_data on data within the same cycle.
module msrv32_rf_read_port
  import msrv32_pkg::*;
#(
  parameter int XLEN       = msrv32_pkg::XLEN,
  parameter int REG_ADDR_W = msrv32_pkg::REG_ADDR_W,
  localparam int DEPTH     = 2 ** REG_ADDR_W
) (
  input  logic                        rst,
  input  logic [REG_ADDR_W-1:0]       addr,
  input  logic [REG_ADDR_W-1:0]       wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic                        wr_en,
  input  logic [DEPTH-1:0][XLEN-1:0]  regs,
  output logic [XLEN-1:0]             data
);

  logic is_x0;
  logic hit;

  assign is_x0 = (addr == REG_ADDR_W'(X0_ADDR));
  assign hit   = wr_en && (wr_addr == addr);

  // x0 outranks the bypass so a write attempted to x0 can never leak through.
  always_comb begin
    data = regs[addr];
    if (rst) begin
      data = '0;
    end else if (is_x0) begin
      data = '0;
    end else if (hit) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/msrv32_integer_file.sv
// msrv32 integer register file x0-x31: two combinational read ports with write-through bypass.
// Writes commit on the rising edge; no backpressure, wr_en_in is already flush-gated upstream.
module msrv32_integer_file
  import msrv32_pkg::*;
#(
  parameter int XLEN       = msrv32_pkg::XLEN,
  parameter int REG_ADDR_W = msrv32_pkg::REG_ADDR_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [XLEN-1:0]       rd_in,
  input  logic                  wr_en_in,
  output logic [XLEN-1:0]       rs_1_out,
  output logic [XLEN-1:0]       rs_2_out
);

  localparam int DEPTH = 2 ** REG_ADDR_W;

  // x0 has no storage; entry 0 of the read view is tied to zero.
  logic [XLEN-1:0]            storage [DEPTH-1:1];
  logic [DEPTH-1:0][XLEN-1:0] reg_view;
  logic                       wr_commit;

  assign wr_commit = wr_en_in && (rd_addr_in != REG_ADDR_W'(X0_ADDR));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 1; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (wr_commit) begin
      storage[rd_addr_in] <= rd_in;
    end
  end

  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      reg_view[i] = storage[i];
    end
  end

  msrv32_rf_read_port #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_read_port_1 (
    .rst     (rst_in),
    .addr    (rs_1_addr_in),
    .wr_addr (rd_addr_in),
    .wr_data (rd_in),
    .wr_en   (wr_en_in),
    .regs    (reg_view),
    .data    (rs_1_out)
  );

  msrv32_rf_read_port #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_read_port_2 (
    .rst     (rst_in),
    .addr    (rs_2_addr_in),
    .wr_addr (rd_addr_in),
    .wr_data (rd_in),
    .wr_en   (wr_en_in),
    .regs    (reg_view),
    .data    (rs_2_out)
  );

endmodule
